// File: rtl/switch_debounce.sv
// Front-panel switch conditioner: two-flop synchroniser, four-state settle FSM,
// and registered level / rise / fall / long-press / toggle outputs.
module switch_debounce #(
  parameter int unsigned DEBOUNCE_CYCLES = 1_000_000,
  parameter int unsigned LONG_CYCLES     = 50_000_000
) (
  input  logic clk_50M,
  input  logic rst_n,
  input  logic sw_raw,
  output logic sw_level,
  output logic rise_pulse,
  output logic fall_pulse,
  output logic long_press,
  output logic toggle
);

  localparam int unsigned CNT_W  = $clog2(DEBOUNCE_CYCLES);
  localparam int unsigned HCNT_W = $clog2(LONG_CYCLES);
  localparam logic [CNT_W-1:0]  CNT_LAST  = CNT_W'(DEBOUNCE_CYCLES - 1);
  localparam logic [HCNT_W-1:0] HCNT_LAST = HCNT_W'(LONG_CYCLES - 1);

  typedef enum logic [1:0] {
    ST_LOW      = 2'd0,
    ST_SETTLE_H = 2'd1,
    ST_HIGH     = 2'd2,
    ST_SETTLE_L = 2'd3
  } state_e;

  state_e              state_q, state_d;
  logic                s1_q, s2_q;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic [HCNT_W-1:0]   hcnt_q, hcnt_d;
  logic                fired_q, fired_d;
  logic                level_q, level_d;
  logic                rise_q, rise_d;
  logic                fall_q, fall_d;
  logic                long_q, long_d;
  logic                tog_q, tog_d;

  // Two-flop synchroniser for the asynchronous pin
  always_ff @(posedge clk_50M or negedge rst_n) begin
    if (!rst_n) begin
      s1_q <= 1'b0;
      s2_q <= 1'b0;
    end else begin
      s1_q <= sw_raw;
      s2_q <= s1_q;
    end
  end

  // FSM, counters and output registers
  always_ff @(posedge clk_50M or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_LOW;
      cnt_q   <= '0;
      hcnt_q  <= '0;
      fired_q <= 1'b0;
      level_q <= 1'b0;
      rise_q  <= 1'b0;
      fall_q  <= 1'b0;
      long_q  <= 1'b0;
      tog_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      hcnt_q  <= hcnt_d;
      fired_q <= fired_d;
      level_q <= level_d;
      rise_q  <= rise_d;
      fall_q  <= fall_d;
      long_q  <= long_d;
      tog_q   <= tog_d;
    end
  end

  // Next-state: fired_q keeps long_press to one pulse per accepted press,
  // surviving release glitches that bounce through SETTLE_L.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    hcnt_d  = hcnt_q;
    fired_d = fired_q;
    level_d = level_q;
    tog_d   = tog_q;
    rise_d  = 1'b0;
    fall_d  = 1'b0;
    long_d  = 1'b0;

    case (state_q)
      ST_LOW: begin
        if (s2_q) begin
          state_d = ST_SETTLE_H;
          cnt_d   = '0;
        end
      end
      ST_SETTLE_H: begin
        if (!s2_q) begin
          state_d = ST_LOW;
          cnt_d   = '0;
        end else if (cnt_q == CNT_LAST) begin
          state_d = ST_HIGH;
          cnt_d   = '0;
          hcnt_d  = '0;
          fired_d = 1'b0;
          level_d = 1'b1;
          rise_d  = 1'b1;
          tog_d   = ~tog_q;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      ST_HIGH: begin
        if (!s2_q) begin
          state_d = ST_SETTLE_L;
          cnt_d   = '0;
        end else if (hcnt_q != HCNT_LAST) begin
          hcnt_d = hcnt_q + HCNT_W'(1);
        end else if (!fired_q) begin
          long_d  = 1'b1;
          fired_d = 1'b1;
        end
      end
      ST_SETTLE_L: begin
        if (s2_q) begin
          state_d = ST_HIGH;
          cnt_d   = '0;
        end else if (cnt_q == CNT_LAST) begin
          state_d = ST_LOW;
          cnt_d   = '0;
          level_d = 1'b0;
          fall_d  = 1'b1;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      default: state_d = ST_LOW;
    endcase
  end

  assign sw_level   = level_q;
  assign rise_pulse = rise_q;
  assign fall_pulse = fall_q;
  assign long_press = long_q;
  assign toggle     = tog_q;

endmodule

// File: tb/tb_switch_debounce.sv
// Scoreboard bench for switch_debounce: stimulus queues expected output events,
// a negedge monitor pops and compares every event the DUT presents.
module tb_switch_debounce;

  localparam int unsigned DEB = 4;
  localparam int unsigned LNG = 10;
  // Input driven at a negedge; first sampling posedge is one cycle later,
  // then two synchroniser/FSM-entry cycles plus DEB settle cycles.
  localparam int unsigned LAT = DEB + 3;

  typedef struct {
    int unsigned cyc;
    logic        lvl;
    logic        rise;
    logic        fall;
    logic        lng;
    logic        tog;
  } exp_t;

  logic clk = 1'b0;
  logic rst_n;
  logic sw_raw;
  logic sw_level, rise_pulse, fall_pulse, long_press, toggle;

  int unsigned cyc = 0;
  int          checks = 0;
  int          errors = 0;
  exp_t        exp_q[$];
  logic        exp_tog = 1'b0;
  logic        prev_lvl = 1'b0;
  logic        prev_tog = 1'b0;
  logic        end_req = 1'b0;
  logic        end_done = 1'b0;

  switch_debounce #(
    .DEBOUNCE_CYCLES(DEB),
    .LONG_CYCLES    (LNG)
  ) dut (
    .clk_50M   (clk),
    .rst_n     (rst_n),
    .sw_raw    (sw_raw),
    .sw_level  (sw_level),
    .rise_pulse(rise_pulse),
    .fall_pulse(fall_pulse),
    .long_press(long_press),
    .toggle    (toggle)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic expect_ev(input int unsigned c, input logic lvl, input logic rise,
                           input logic fall, input logic lng, input logic tog);
    exp_t e;
    e.cyc = c; e.lvl = lvl; e.rise = rise; e.fall = fall; e.lng = lng; e.tog = tog;
    exp_q.push_back(e);
  endtask

  task automatic hold(input logic v, input int n);
    sw_raw = v;
    repeat (n) @(negedge clk);
  endtask

  task automatic press();
    exp_tog = ~exp_tog;
    expect_ev(cyc + LAT, 1'b1, 1'b1, 1'b0, 1'b0, exp_tog);
  endtask

  task automatic release_sw();
    expect_ev(cyc + LAT, 1'b0, 1'b0, 1'b1, 1'b0, exp_tog);
  endtask

  task automatic async_reset();
    @(posedge clk);
    #2 rst_n = 1'b0;
    exp_tog = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
  endtask

  // Monitor: reset-zero checks, event compares, final leftover check
  always @(negedge clk) begin
    if (end_req && !end_done) begin
      checks++;
      if (exp_q.size() != 0) begin
        errors++;
        $display("FAIL leftover: %0d expected events never seen (first due cyc=%0d)",
                 exp_q.size(), exp_q[0].cyc);
      end
      end_done = 1'b1;
    end else if (!rst_n) begin
      checks++;
      if ({sw_level, rise_pulse, fall_pulse, long_press, toggle} != 5'b0) begin
        errors++;
        $display("FAIL reset_zero cyc=%0d: got lvl=%b rise=%b fall=%b long=%b tog=%b, expected all 0",
                 cyc, sw_level, rise_pulse, fall_pulse, long_press, toggle);
      end
    end else if (rise_pulse || fall_pulse || long_press ||
                 sw_level != prev_lvl || toggle != prev_tog) begin
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL unexpected_event cyc=%0d: got lvl=%b rise=%b fall=%b long=%b tog=%b, expected none",
                 cyc, sw_level, rise_pulse, fall_pulse, long_press, toggle);
      end else begin
        exp_t e;
        e = exp_q.pop_front();
        if (cyc != e.cyc || sw_level != e.lvl || rise_pulse != e.rise ||
            fall_pulse != e.fall || long_press != e.lng || toggle != e.tog) begin
          errors++;
          $display("FAIL event: got cyc=%0d lvl=%b rise=%b fall=%b long=%b tog=%b, expected cyc=%0d lvl=%b rise=%b fall=%b long=%b tog=%b",
                   cyc, sw_level, rise_pulse, fall_pulse, long_press, toggle,
                   e.cyc, e.lvl, e.rise, e.fall, e.lng, e.tog);
        end
      end
    end
    prev_lvl = sw_level;
    prev_tog = toggle;
  end

  initial begin
    rst_n  = 1'b0;
    sw_raw = 1'b0;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

    // Clean press, long press after LNG cycles, post-fire glitch, release
    press();
    expect_ev(cyc + LAT + LNG, 1'b1, 1'b0, 1'b0, 1'b1, exp_tog);
    hold(1'b1, LAT + 20);
    hold(1'b0, 2);
    hold(1'b1, 8);
    release_sw();
    hold(1'b0, 10);

    // Bounce rejection: 3-cycle highs never settle
    repeat (4) begin
      hold(1'b1, 3);
      hold(1'b0, 3);
    end
    press();
    hold(1'b1, 10);
    release_sw();
    hold(1'b0, 10);

    // Toggle sequence over three clean press/release cycles
    repeat (3) begin
      press();
      hold(1'b1, 10);
      release_sw();
      hold(1'b0, 10);
    end

    // Async reset during SETTLE_H, then during HIGH; pin held high across release
    hold(1'b1, 4);
    async_reset();
    press();
    hold(1'b1, 12);
    async_reset();
    press();
    hold(1'b1, 10);
    release_sw();
    hold(1'b0, 10);

    end_req = 1'b1;
    repeat (2) @(negedge clk);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
